watch_time_core: RTL and testbench

- Parametrised BCD time-of-day counter for the wristwatch datapath. Replaces the two-clock minute/hour counter with a single-clock design.
- Contains an internal 1 Hz prescaler, a seconds field, 12 h or 24 h hour formats, and a set mode with edge-detected minute and hour increment buttons that do not carry.
- Drives the seven-segment digit mux and the alarm comparator.

---
 rtl/watch_time_core.sv | 162 ++++++++++++++++
 tb/tb_watch_time_core.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/watch_time_core.sv
// BCD time-of-day counter with 1 Hz prescaler, 12/24 h formats and a non-carrying set mode.
// All digit and pulse outputs are registered: they change one edge after the cause, with no stall path.
module watch_time_core #(
  parameter int TICK_DIV  = 50000000,
  parameter int TWELVE_HR = 0,
  parameter int INIT_HH   = 12,
  parameter int INIT_MM   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_mode,
  input  logic       btn_min,
  input  logic       btn_hr,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] hr_tens,
  output logic       pm,
  output logic       sec_pulse,
  output logic       min_pulse
);

  localparam int             PW           = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX    = PW'(TICK_DIV - 1);
  localparam logic [7:0]     INIT_HR_BCD  = {4'(INIT_HH / 10), 4'(INIT_HH % 10)};
  localparam logic [7:0]     INIT_MIN_BCD = {4'(INIT_MM / 10), 4'(INIT_MM % 10)};
  localparam logic           INIT_PM      = (TWELVE_HR == 0) && (INIT_HH >= 12);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    hr_q, hr_d;
  logic          pm_q, pm_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic          min_pulse_q, min_pulse_d;
  logic          btn_min_q, btn_hr_q;

  logic [8:0]    sec_step, min_step, hr_step;
  logic          min_edge, hr_edge;

  // Returns {wrap, next} for a two-digit BCD field counting 00..59.
  function automatic logic [8:0] inc60(input logic [7:0] v);
    logic [8:0] r;
    if (v[3:0] != 4'd9) begin
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    end else if (v[7:4] != 4'd5) begin
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    end else begin
      r = 9'h100;
    end
    return r;
  endfunction

  // Returns {pm_next, hour_next} for one hour step in the selected format.
  function automatic logic [8:0] hr_inc(input logic [7:0] h, input logic p);
    logic [7:0] n;
    logic       np;
    np = p;
    if (TWELVE_HR != 0) begin
      if (h == 8'h12) begin
        n = 8'h01;
      end else if (h == 8'h11) begin
        n  = 8'h12;
        np = ~p;
      end else if (h[3:0] == 4'd9) begin
        n = {h[7:4] + 4'd1, 4'd0};
      end else begin
        n = {h[7:4], h[3:0] + 4'd1};
      end
    end else begin
      if (h == 8'h23) begin
        n = 8'h00;
      end else if (h[3:0] == 4'd9) begin
        n = {h[7:4] + 4'd1, 4'd0};
      end else begin
        n = {h[7:4], h[3:0] + 4'd1};
      end
      // BCD preserves numeric ordering, so a plain compare gives hour >= 12.
      np = (n >= 8'h12);
    end
    return {np, n};
  endfunction

  assign sec_step = inc60(sec_q);
  assign min_step = inc60(min_q);
  assign hr_step  = hr_inc(hr_q, pm_q);
  assign min_edge = btn_min & ~btn_min_q;
  assign hr_edge  = btn_hr & ~btn_hr_q;

  always_comb begin
    presc_d     = presc_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;
    pm_d        = pm_q;
    sec_pulse_d = 1'b0;
    min_pulse_d = 1'b0;
    if (set_mode) begin
      // Setting never carries between fields; each button edges only its own field.
      presc_d = '0;
      sec_d   = 8'h00;
      if (min_edge) begin
        min_d = min_step[7:0];
      end
      if (hr_edge) begin
        pm_d = hr_step[8];
        hr_d = hr_step[7:0];
      end
    end else if (presc_q == PRESC_MAX) begin
      presc_d     = '0;
      sec_d       = sec_step[7:0];
      sec_pulse_d = 1'b1;
      if (sec_step[8]) begin
        min_d       = min_step[7:0];
        min_pulse_d = 1'b1;
        if (min_step[8]) begin
          pm_d = hr_step[8];
          hr_d = hr_step[7:0];
        end
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      sec_q       <= 8'h00;
      min_q       <= INIT_MIN_BCD;
      hr_q        <= INIT_HR_BCD;
      pm_q        <= INIT_PM;
      sec_pulse_q <= 1'b0;
      min_pulse_q <= 1'b0;
      btn_min_q   <= 1'b0;
      btn_hr_q    <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      pm_q        <= pm_d;
      sec_pulse_q <= sec_pulse_d;
      min_pulse_q <= min_pulse_d;
      btn_min_q   <= btn_min;
      btn_hr_q    <= btn_hr;
    end
  end

  assign sec_ones  = sec_q[3:0];
  assign sec_tens  = sec_q[7:4];
  assign min_ones  = min_q[3:0];
  assign min_tens  = min_q[7:4];
  assign hr_ones   = hr_q[3:0];
  assign hr_tens   = hr_q[7:4];
  assign pm        = pm_q;
  assign sec_pulse = sec_pulse_q;
  assign min_pulse = min_pulse_q;

endmodule

// File: tb/tb_watch_time_core.sv
// Two watch cores (24 h from 23:59, 12 h from 11:59 AM) checked every cycle against a
// seconds-of-day model, plus literal spot checks of the scenarios that pin the model.
module tb_watch_time_core;
  localparam int TD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2], setm[2], bmin[2], bhr[2];
  logic [3:0] so[2], st[2], mo[2], mt[2], ho[2], ht[2];
  logic       o_pm[2], o_sp[2], o_mp[2];

  watch_time_core #(.TICK_DIV(TD), .TWELVE_HR(0), .INIT_HH(23), .INIT_MM(59)) u_a (
    .clk(clk), .reset(rst[0]), .set_mode(setm[0]), .btn_min(bmin[0]), .btn_hr(bhr[0]),
    .sec_ones(so[0]), .sec_tens(st[0]), .min_ones(mo[0]), .min_tens(mt[0]),
    .hr_ones(ho[0]), .hr_tens(ht[0]), .pm(o_pm[0]), .sec_pulse(o_sp[0]), .min_pulse(o_mp[0])
  );

  watch_time_core #(.TICK_DIV(TD), .TWELVE_HR(1), .INIT_HH(11), .INIT_MM(59)) u_b (
    .clk(clk), .reset(rst[1]), .set_mode(setm[1]), .btn_min(bmin[1]), .btn_hr(bhr[1]),
    .sec_ones(so[1]), .sec_tens(st[1]), .min_ones(mo[1]), .min_tens(mt[1]),
    .hr_ones(ho[1]), .hr_tens(ht[1]), .pm(o_pm[1]), .sec_pulse(o_sp[1]), .min_pulse(o_mp[1])
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit armed = 1'b0;

  // Model: hour kept as 0..23 for both formats; 12 h display is derived from it.
  int tw[2]      = '{0, 1};
  int init_h[2]  = '{23, 11};
  int init_mm[2] = '{59, 59};
  int m_presc[2], m_sec[2], m_min[2], m_h[2];
  bit m_sp[2], m_mp[2], m_pbm[2], m_pbh[2];

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_presc[i] = 0; m_sec[i] = 0; m_min[i] = init_mm[i]; m_h[i] = init_h[i];
        m_sp[i] = 0; m_mp[i] = 0; m_pbm[i] = 0; m_pbh[i] = 0;
      end else begin
        m_sp[i] = 0;
        m_mp[i] = 0;
        if (setm[i]) begin
          m_presc[i] = 0;
          m_sec[i] = 0;
          if (bmin[i] && !m_pbm[i]) m_min[i] = (m_min[i] + 1) % 60;
          if (bhr[i] && !m_pbh[i]) m_h[i] = (m_h[i] + 1) % 24;
        end else if (m_presc[i] == TD - 1) begin
          m_presc[i] = 0;
          m_sp[i] = 1;
          m_sec[i] = m_sec[i] + 1;
          if (m_sec[i] == 60) begin
            m_sec[i] = 0;
            m_mp[i] = 1;
            m_min[i] = m_min[i] + 1;
            if (m_min[i] == 60) begin
              m_min[i] = 0;
              m_h[i] = (m_h[i] + 1) % 24;
            end
          end
        end else begin
          m_presc[i] = m_presc[i] + 1;
        end
        m_pbm[i] = bmin[i];
        m_pbh[i] = bhr[i];
      end
    end
  end

  function automatic int disp_hr(input int i);
    if (tw[i] != 0) return (m_h[i] % 12 == 0) ? 12 : m_h[i] % 12;
    return m_h[i];
  endfunction

  function automatic logic [26:0] exp_vec(input int i);
    int hd;
    hd = disp_hr(i);
    return {4'(hd / 10), 4'(hd % 10), 4'(m_min[i] / 10), 4'(m_min[i] % 10),
            4'(m_sec[i] / 10), 4'(m_sec[i] % 10), m_h[i] >= 12, m_sp[i], m_mp[i]};
  endfunction

  function automatic logic [26:0] dut_vec(input int i);
    return {ht[i], ho[i], mt[i], mo[i], st[i], so[i], o_pm[i], o_sp[i], o_mp[i]};
  endfunction

  function automatic int dut_time(input int i);
    return ht[i] * 100000 + ho[i] * 10000 + mt[i] * 1000 + mo[i] * 100 + st[i] * 10 + so[i];
  endfunction

  initial forever begin
    @(negedge clk);
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (dut_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL model_cmp inst%0d t=%0t got=%h expected=%h", i, $time, dut_vec(i), exp_vec(i));
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic press(input int i, input bit hr);
    if (hr) bhr[i] = 1'b1; else bmin[i] = 1'b1;
    @(negedge clk);
    bhr[i] = 1'b0;
    bmin[i] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int last;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; setm[i] = 1'b0; bmin[i] = 1'b0; bhr[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    armed = 1'b1;
    chk("reset_a_time", dut_time(0), 235900);
    chk("reset_a_pm", int'(o_pm[0]), 1);
    chk("reset_b_time", dut_time(1), 115900);
    chk("reset_b_pm", int'(o_pm[1]), 0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Full-day rollover after 240 cycles.
    repeat (239) @(negedge clk);
    chk("a_pre_roll_time", dut_time(0), 235959);
    chk("a_pre_roll_pm", int'(o_pm[0]), 1);
    @(negedge clk);
    chk("a_roll_time", dut_time(0), 0);
    chk("a_roll_sp", int'(o_sp[0]), 1);
    chk("a_roll_mp", int'(o_mp[0]), 1);
    chk("a_roll_pm", int'(o_pm[0]), 0);
    chk("b_noon_time", dut_time(1), 120000);
    chk("b_noon_pm", int'(o_pm[1]), 1);
    repeat (3600 * TD) @(negedge clk);
    chk("b_one_pm_time", dut_time(1), 10000);
    chk("b_one_pm_pm", int'(o_pm[1]), 1);
    chk("a_one_am_time", dut_time(0), 10000);

    // Set mode, held minute button then 61 presses.
    setm[0] = 1'b1;
    bmin[0] = 1'b1;
    repeat (10) @(negedge clk);
    bmin[0] = 1'b0;
    @(negedge clk);
    chk("a_held_btn", dut_time(0), 10100);
    repeat (61) press(0, 1'b0);
    chk("a_61_presses", dut_time(0), 10200);

    // 12 h: set to 11:59 AM, then both buttons together.
    setm[1] = 1'b1;
    repeat (22) press(1, 1'b1);
    repeat (59) press(1, 1'b0);
    chk("b_set_1159", dut_time(1), 115900);
    chk("b_set_1159_pm", int'(o_pm[1]), 0);
    bmin[1] = 1'b1;
    bhr[1] = 1'b1;
    @(negedge clk);
    chk("b_both_btn", dut_time(1), 120000);
    chk("b_both_btn_pm", int'(o_pm[1]), 1);
    bmin[1] = 1'b0;
    bhr[1] = 1'b0;
    @(negedge clk);
    setm[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_exit_early_sp", int'(o_sp[1]), 0);
    @(negedge clk);
    chk("b_exit_sp", int'(o_sp[1]), 1);
    chk("b_exit_time", dut_time(1), 120001);

    // Reach 05:17:33 mid-prescale, then a one-cycle reset.
    repeat (4) press(0, 1'b1);
    repeat (15) press(0, 1'b0);
    setm[0] = 1'b0;
    repeat (33 * TD + 2) @(negedge clk);
    chk("a_051733", dut_time(0), 51733);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("a_rst_time", dut_time(0), 235900);
    chk("a_rst_sp", int'(o_sp[0]), 0);
    chk("a_rst_mp", int'(o_mp[0]), 0);
    chk("a_rst_pm", int'(o_pm[0]), 1);
    repeat (3) @(negedge clk);
    chk("a_rst_early_sp", int'(o_sp[0]), 0);
    @(negedge clk);
    chk("a_rst_first_sp", int'(o_sp[0]), 1);

    // Button activity outside set mode must not disturb timekeeping.
    last = -1;
    for (int k = 0; k < 64; k++) begin
      bmin[0] = k[0];
      bhr[0] = k[1];
      @(negedge clk);
      if (o_sp[0]) begin
        chk("a_sp_spacing", k - last, TD);
        last = k;
      end
    end
    bmin[0] = 1'b0;
    bhr[0] = 1'b0;
    chk("a_btn_ignored_time", dut_time(0), 235917);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
